// File: rtl/wt_divider.sv
// Sequential unsigned radix-2 restoring divider: 2N-bit dividend / N-bit divisor,
// start/busy/done handshake, registered quotient, remainder and result flags.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start; busy=0
// S_RUN    | one restoring iteration per edge, cnt = 0..N-1
// S_FINISH | one edge: commit result and flags, pulse done, back to idle

module wt_divider #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  // Partial remainder kept N bits wide: it always stays below the divisor,
  // so only the shifted trial value needs the extra bit.
  logic [N-1:0]  p_reg;
  logic [N-1:0]  q_reg;
  logic [N-1:0]  dvs_reg;
  logic          dz_pend;
  logic          ov_pend;

  logic [N:0]    trial;
  logic          trial_ge;
  logic [N-1:0]  trial_diff;
  logic          op_special;

  assign trial      = {p_reg, q_reg[N-1]};
  assign trial_ge   = (trial >= {1'b0, dvs_reg});
  assign trial_diff = trial[N-1:0] - dvs_reg;
  assign op_special = (divisor == '0) || (dividend[2*N-1:N] >= divisor);
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = op_special ? S_FINISH : S_RUN;
      S_RUN:    if (cnt == CNT_LAST) state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt         <= '0;
      p_reg       <= '0;
      q_reg       <= '0;
      dvs_reg     <= '0;
      dz_pend     <= 1'b0;
      ov_pend     <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            cnt     <= '0;
            p_reg   <= dividend[2*N-1:N];
            q_reg   <= dividend[N-1:0];
            dvs_reg <= divisor;
            dz_pend <= (divisor == '0);
            ov_pend <= (divisor != '0) && (dividend[2*N-1:N] >= divisor);
          end
        end
        S_RUN: begin
          p_reg <= trial_ge ? trial_diff : trial[N-1:0];
          q_reg <= {q_reg[N-2:0], trial_ge};
          cnt   <= cnt + CW'(1);
        end
        S_FINISH: begin
          done        <= 1'b1;
          div_by_zero <= dz_pend;
          overflow    <= ov_pend;
          if (dz_pend) begin
            // No iterations ran, so q_reg still holds the dividend low half.
            quotient  <= '1;
            remainder <= q_reg;
          end else if (ov_pend) begin
            quotient  <= '1;
            remainder <= '0;
          end else begin
            quotient  <= q_reg;
            remainder <= p_reg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wt_divider.sv
// Directed and random-product checks for wt_divider: latency, busy/done
// handshake, special cases, ignored start, back-to-back and mid-run reset.

module tb_wt_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [63:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero, overflow;
  logic [31:0] quotient, remainder;

  int n_checks = 0;
  int n_errors = 0;

  wt_divider #(.N(32)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend),
    .divisor(divisor), .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Call #1 after a rising edge; returns #1 after the sampling edge.
  task automatic start_op(input logic [63:0] dvd, input logic [31:0] dvs);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) bcnt++;
    end
    if (lat == 0) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic div_check(input string tag, input logic [63:0] dvd, input logic [31:0] dvs,
                           input logic [31:0] eq, input logic [31:0] er,
                           input logic edz, input logic eov, input int elat);
    int lat, bcnt;
    start_op(dvd, dvs);
    wait_done(lat, bcnt);
    check({tag, "_lat"}, 64'(lat), 64'(elat));
    check({tag, "_busycnt"}, 64'(bcnt), 64'(elat - 1));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_q"}, 64'(quotient), 64'(eq));
    check({tag, "_r"}, 64'(remainder), 64'(er));
    check({tag, "_dz"}, 64'(div_by_zero), 64'(edz));
    check({tag, "_ov"}, 64'(overflow), 64'(eov));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int lat, bcnt, seen;
    logic [31:0] a, b, r;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_q", 64'(quotient), 64'd0);
    check("rst_r", 64'(remainder), 64'd0);
    check("rst_flags", 64'({div_by_zero, overflow}), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    div_check("basic", 64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33);
    div_check("inverse", 64'hFFFFFFFE_00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 33);
    div_check("exact", 64'd12, 32'd4, 32'd3, 32'd0, 1'b0, 1'b0, 33);
    div_check("by_one", 64'h00000000_DEADBEEF, 32'd1, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0, 33);
    div_check("small", 64'd5, 32'd9, 32'd0, 32'd5, 1'b0, 1'b0, 33);
    div_check("dbz", 64'h12345678_9ABCDEF0, 32'd0, 32'hFFFFFFFF, 32'h9ABCDEF0, 1'b1, 1'b0, 1);
    div_check("ovf", 64'h00000005_00000000, 32'd5, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 1);
    div_check("ovf_edge", 64'h00000006_00000000, 32'd5, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 1);
    div_check("after_ovf", 64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33);
    // Largest non-overflowing high half: hi = divisor-1.
    div_check("hi_max", 64'h00000004_FFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd4, 1'b0, 1'b0, 33);

    // Ignored start during a run.
    start_op(64'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    dividend = 64'd50; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bcnt);
    check("ign_lat", 64'(lat + 5), 64'd33);
    check("ign_q", 64'(quotient), 64'd14);
    check("ign_r", 64'(remainder), 64'd2);

    // Back-to-back: start 9/4 during the done cycle of a 100/7 run.
    start_op(64'd100, 32'd7);
    wait_done(lat, bcnt);
    check("b2b_first_q", 64'(quotient), 64'd14);
    start_op(64'd9, 32'd4);
    check("b2b_done_drop", 64'(done), 64'd0);
    check("b2b_busy_rise", 64'(busy), 64'd1);
    wait_done(lat, bcnt);
    check("b2b_lat", 64'(lat), 64'd33);
    check("b2b_q", 64'(quotient), 64'd2);
    check("b2b_r", 64'(remainder), 64'd1);
    @(posedge clk); #1;

    // Reset mid-run at iteration 10.
    start_op(64'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    check("mrst_q", 64'(quotient), 64'd0);
    check("mrst_r", 64'(remainder), 64'd0);
    check("mrst_flags", 64'({div_by_zero, overflow}), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("mrst_no_done", 64'(seen), 64'd0);
    div_check("after_rst", 64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33);

    // Random products: dividend = a*b + r with r < b never overflows.
    for (int k = 0; k < 1000; k++) begin
      a = $urandom;
      b = $urandom;
      if (k % 4 == 1) b = 32'($urandom_range(1, 255));
      if (b == 0) b = 32'd1;
      r = $urandom % b;
      start_op(64'(a) * 64'(b) + 64'(r), b);
      wait_done(lat, bcnt);
      check("rnd_q", 64'(quotient), 64'(a));
      check("rnd_r", 64'(remainder), 64'(r));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
